// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer that lets two bus masters share one async byte-wide SRAM.
// Every SRAM pin comes from a register, so the strobes cannot glitch and they release as soon as reset asserts.
module sram_arbiter #(
  parameter int AW          = 19,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          sram_ce_bar,
  output logic          sram_oe_bar,
  output logic          sram_we_bar,
  inout  wire  [DW-1:0] sram_data,
  output logic [AW-1:0] sram_addr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t        state, next_state;
  logic [3:0]    cnt;
  logic          last_grant, grant, any_valid, handshake, leaving_access;
  logic          port_q, we_q, drive_q;
  logic [DW-1:0] wdata_q;
  logic          next_we, ce_d, oe_d, we_d, drive_d;

  // Port 0 wins when port 1 held the previous grant.
  always_comb begin
    grant = 1'b0;
    if (p0_req_valid && p1_req_valid) grant = ~last_grant;
    else if (p1_req_valid)            grant = 1'b1;
  end

  assign any_valid      = p0_req_valid | p1_req_valid;
  assign handshake      = (state == IDLE) && any_valid;
  assign p0_req_ready   = handshake && !grant;
  assign p1_req_ready   = handshake && grant;
  assign leaving_access = (state == ACCESS) && (cnt == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (handshake) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The pins are registered from the next state. During the handshake cycle we_q has not been loaded yet, so the request's we bit is used.
  assign next_we = handshake ? (grant ? p1_req_we : p0_req_we) : we_q;

  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    drive_d = 1'b0;
    unique case (next_state)
      SETUP:  begin ce_d = 1'b0; drive_d = next_we; end
      ACCESS: begin ce_d = 1'b0; oe_d = next_we; we_d = ~next_we; drive_d = next_we; end
      DONE:   begin ce_d = 1'b0; drive_d = next_we; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= 4'd0;
      last_grant   <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      sram_addr    <= '0;
      sram_ce_bar  <= 1'b1;
      sram_oe_bar  <= 1'b1;
      sram_we_bar  <= 1'b1;
      drive_q      <= 1'b0;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      sram_ce_bar  <= ce_d;
      sram_oe_bar  <= oe_d;
      sram_we_bar  <= we_d;
      drive_q      <= drive_d;
      p0_rsp_valid <= leaving_access && !port_q;
      p1_rsp_valid <= leaving_access && port_q;
      if (handshake) begin
        port_q     <= grant;
        we_q       <= next_we;
        sram_addr  <= grant ? p1_req_addr  : p0_req_addr;
        wdata_q    <= grant ? p1_req_wdata : p0_req_wdata;
        last_grant <= grant;
      end
      if (state == SETUP)                      cnt <= CNT_LOAD;
      else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (leaving_access && !we_q) begin
        if (port_q) p1_rsp_rdata <= sram_data;
        else        p0_rsp_rdata <= sram_data;
      end
    end
  end

  assign sram_data = drive_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench with three arbiter builds (WAIT_CYCLES = 2, 1, 15), each attached to its own behavioural SRAM.
// Single transactions come from a directed vector table; contention, back-to-back and reset are hand-written sequences.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        p_valid [3][2];
  logic        p_we    [3][2];
  logic [18:0] p_addr  [3][2];
  logic [7:0]  p_wdata [3][2];
  wire         p_ready [3][2];
  wire         p_rsp   [3][2];
  wire  [7:0]  p_rdata [3][2];
  wire         ce [3];
  wire         oe [3];
  wire         we_b [3];
  wire  [18:0] saddr [3];
  wire  [7:0]  sdata_mon [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [7:0] mem [0:524287];
    wire  [7:0] sdata;

    sram_arbiter #(.AW(19), .DW(8), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rstn(rstn),
      .p0_req_valid(p_valid[g][0]), .p0_req_ready(p_ready[g][0]), .p0_req_we(p_we[g][0]),
      .p0_req_addr(p_addr[g][0]), .p0_req_wdata(p_wdata[g][0]),
      .p0_rsp_valid(p_rsp[g][0]), .p0_rsp_rdata(p_rdata[g][0]),
      .p1_req_valid(p_valid[g][1]), .p1_req_ready(p_ready[g][1]), .p1_req_we(p_we[g][1]),
      .p1_req_addr(p_addr[g][1]), .p1_req_wdata(p_wdata[g][1]),
      .p1_rsp_valid(p_rsp[g][1]), .p1_rsp_rdata(p_rdata[g][1]),
      .sram_ce_bar(ce[g]), .sram_oe_bar(oe[g]), .sram_we_bar(we_b[g]),
      .sram_data(sdata), .sram_addr(saddr[g])
    );

    assign sdata = (!ce[g] && !oe[g] && we_b[g]) ? mem[saddr[g]] : 8'bz;
    assign sdata_mon[g] = sdata;
    always @(posedge clk) if (!ce[g] && !we_b[g]) mem[saddr[g]] = sdata;
    initial if (g == 0) mem[19'h12345] = 8'hA5;
  end

  typedef struct {
    int          port;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [7];

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Runs one request to completion. The cycle counter is 0 in the handshake cycle.
  task automatic do_txn(input int k, input int port, input logic we, input logic [18:0] addr,
                        input logic [7:0] wd, output int lat, output int sw, output int bad,
                        output bit pins_ok, output bit other_rsp);
    int n;
    lat = -1; sw = 0; bad = 0; pins_ok = 1'b1; other_rsp = 1'b0;
    @(negedge clk);
    p_valid[k][port] = 1'b1; p_we[k][port] = we; p_addr[k][port] = addr; p_wdata[k][port] = wd;
    #1;
    n = 0;
    while (!p_ready[k][port] && n < 50) begin @(negedge clk); #1; n++; end
    check("ready_wait", 32'(n < 50), 1);
    if (n >= 50) begin p_valid[k][port] = 1'b0; return; end
    @(negedge clk);
    p_valid[k][port] = 1'b0; p_addr[k][port] = '0; p_wdata[k][port] = '0;
    lat = 1;
    while (lat < 50) begin
      if (p_rsp[k][1-port]) other_rsp = 1'b1;
      if (ce[k] || saddr[k] != addr) pins_ok = 1'b0;
      if (we && sdata_mon[k] != wd) pins_ok = 1'b0;
      if (p_rsp[k][port]) break;
      if (we ? !we_b[k] : !oe[k]) sw++;
      if (we ? !oe[k] : !we_b[k]) bad++;
      @(negedge clk); lat++;
    end
  endtask

  initial begin
    int lat, sw, bad, n, cyc, prev, hs_cnt;
    bit pins_ok, other_rsp, both;
    int grants [6];

    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        p_valid[k][p] = 1'b0; p_we[k][p] = 1'b0; p_addr[k][p] = '0; p_wdata[k][p] = '0;
      end

    vecs[0] = '{0, 1'b0, 19'h12345, 8'h00, 8'hA5};
    vecs[1] = '{1, 1'b1, 19'h7FFFF, 8'h3C, 8'h00};
    vecs[2] = '{1, 1'b0, 19'h7FFFF, 8'h00, 8'h3C};
    vecs[3] = '{0, 1'b1, 19'h00000, 8'h5A, 8'hA5};
    vecs[4] = '{0, 1'b0, 19'h00000, 8'h00, 8'h5A};
    vecs[5] = '{1, 1'b1, 19'h00001, 8'hC3, 8'h3C};
    vecs[6] = '{0, 1'b0, 19'h00001, 8'h00, 8'hC3};

    #12;
    check("rst_pins", {29'd0, ce[0], oe[0], we_b[0]}, 3'b111);
    check("rst_addr", 32'(saddr[0]), 0);
    check("rst_rsp", {30'd0, p_rsp[0][0], p_rsp[0][1]}, 0);
    check("rst_rdata", {16'd0, p_rdata[0][0], p_rdata[0][1]}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset asserted in the middle of the ACCESS phase of a write.
    @(negedge clk);
    p_valid[0][0] = 1'b1; p_we[0][0] = 1'b1; p_addr[0][0] = 19'h00100; p_wdata[0][0] = 8'h99;
    #1;
    n = 0;
    while (!p_ready[0][0] && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    p_valid[0][0] = 1'b0;
    n = 0;
    while (we_b[0] && n < 20) begin @(negedge clk); n++; end
    check("midrst_we_low", 32'(we_b[0]), 0);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_ce_we", {30'd0, ce[0], we_b[0]}, 2'b11);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p_rsp[0][0] || p_rsp[0][1]) n++;
    end
    check("midrst_no_rsp", 32'(n), 0);

    // Both ports keep valid asserted. Grants alternate and start with port 0.
    do_reset();
    @(negedge clk);
    p_valid[0][0] = 1'b1; p_we[0][0] = 1'b0; p_addr[0][0] = 19'h00010;
    p_valid[0][1] = 1'b1; p_we[0][1] = 1'b0; p_addr[0][1] = 19'h00020;
    #1;
    hs_cnt = 0; both = 1'b0; cyc = 0;
    while (hs_cnt < 6 && cyc < 200) begin
      if (p_ready[0][0] && p_ready[0][1]) both = 1'b1;
      if (p_ready[0][0])      begin grants[hs_cnt] = 0; hs_cnt++; end
      else if (p_ready[0][1]) begin grants[hs_cnt] = 1; hs_cnt++; end
      @(negedge clk); #1; cyc++;
    end
    p_valid[0][0] = 1'b0; p_valid[0][1] = 1'b0;
    check("cont_handshakes", 32'(hs_cnt), 6);
    check("cont_never_both", 32'(both), 0);
    for (int i = 0; i < 6; i++)
      if (i < hs_cnt) check($sformatf("cont_grant%0d", i), 32'(grants[i]), 32'(i % 2));
    repeat (8) @(negedge clk);

    // Single transactions from the vector table on the WAIT_CYCLES=2 build.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_txn(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, sw, bad, pins_ok, other_rsp);
      check($sformatf("v%0d_latency", i), 32'(lat), 4);
      check($sformatf("v%0d_strobe", i), 32'(sw), 2);
      check($sformatf("v%0d_other_strobe", i), 32'(bad), 0);
      check($sformatf("v%0d_pins", i), 32'(pins_ok), 1);
      check($sformatf("v%0d_other_rsp", i), 32'(other_rsp), 0);
      check($sformatf("v%0d_rdata", i), 32'(p_rdata[0][vecs[i].port]), 32'(vecs[i].exp_rdata));
    end
    check("mem_7ffff", 32'(g_dut[0].mem[19'h7FFFF]), 32'h3C);

    // Port 0 keeps valid asserted while port 1 stays idle. Handshakes must be WAIT_CYCLES+3 cycles apart.
    @(negedge clk);
    p_valid[0][0] = 1'b1; p_we[0][0] = 1'b0; p_addr[0][0] = 19'h12345;
    #1;
    hs_cnt = 0; cyc = 0; prev = -1; n = 0;
    while (hs_cnt < 4 && cyc < 100) begin
      if (p_ready[0][1] || p_rsp[0][1]) n++;
      if (p_ready[0][0]) begin
        if (prev >= 0) check($sformatf("b2b_gap%0d", hs_cnt), 32'(cyc - prev), 5);
        prev = cyc; hs_cnt++;
      end
      @(negedge clk); #1; cyc++;
    end
    p_valid[0][0] = 1'b0;
    check("b2b_handshakes", 32'(hs_cnt), 4);
    check("b2b_p1_idle", 32'(n), 0);
    repeat (8) @(negedge clk);

    // WAIT_CYCLES=1 and 15 builds: check strobe width and read-after-write.
    for (int k = 1; k < 3; k++) begin
      do_txn(k, 0, 1'b1, 19'h00ABC, 8'h70 + 8'(k), lat, sw, bad, pins_ok, other_rsp);
      check($sformatf("w%0d_wr_strobe", k), 32'(sw), 32'(wait_of(k)));
      check($sformatf("w%0d_wr_latency", k), 32'(lat), 32'(wait_of(k) + 2));
      check($sformatf("w%0d_wr_pins", k), 32'(pins_ok), 1);
      do_txn(k, 1, 1'b0, 19'h00ABC, 8'h00, lat, sw, bad, pins_ok, other_rsp);
      check($sformatf("w%0d_rd_strobe", k), 32'(sw), 32'(wait_of(k)));
      check($sformatf("w%0d_rd_latency", k), 32'(lat), 32'(wait_of(k) + 2));
      check($sformatf("w%0d_rd_data", k), 32'(p_rdata[k][1]), 32'h70 + 32'(k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
